// File: rtl/move_arbiter.sv
// move_arbiter: round-robin WASD keycode arbiter feeding the sprite motion datapath.
// Optional MOVE_AUTOREPEAT_EN: held keys re-request every pass (no per-press locks).
module move_arbiter #(
    parameter int NUM_KEYS    = 4,
    parameter int HOLD_CYCLES = 4,
    localparam int SW = $clog2(NUM_KEYS),
    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  enable,
    input  logic [NUM_KEYS*8-1:0] keycodes,
    input  logic                  move_ready,
    output logic                  move_valid,
    output logic [1:0]            move_dir,
    output logic [SW-1:0]         grant_slot,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [1:0]          dir_q, dir_d;
    logic [NUM_KEYS-1:0] key_ok;
    logic [NUM_KEYS-1:0] req;
    logic [1:0]          key_dir [NUM_KEYS];
    logic                win_found;
    logic [SW-1:0]       win_slot;
    logic [1:0]          win_dir;
    logic                xfer;

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_ok[i]  = 1'b1;
            key_dir[i] = 2'b00;
            unique case (keycodes[8*i +: 8])
                8'h1A:   key_dir[i] = 2'b00;
                8'h04:   key_dir[i] = 2'b01;
                8'h16:   key_dir[i] = 2'b10;
                8'h07:   key_dir[i] = 2'b11;
                default: key_ok[i]  = 1'b0;
            endcase
        end
    end

`ifdef MOVE_AUTOREPEAT_EN
    assign req = key_ok;
`else
    logic [NUM_KEYS-1:0] lock_q;
    logic [7:0]          code_q [NUM_KEYS];

    assign req = key_ok & ~lock_q;

    // A lock holds until the slot shows any code other than the one it moved on.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lock_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                code_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (xfer && slot_q == SW'(i)) begin
                    lock_q[i] <= 1'b1;
                    code_q[i] <= keycodes[8*i +: 8];
                end else if (keycodes[8*i +: 8] != code_q[i]) begin
                    lock_q[i] <= 1'b0;
                end
            end
        end
    end
`endif

    // Rotating search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_slot  = '0;
        for (int k = 1; k <= NUM_KEYS; k++) begin
            if (!win_found && req[(int'(ptr_q) + k) % NUM_KEYS]) begin
                win_found = 1'b1;
                win_slot  = SW'((int'(ptr_q) + k) % NUM_KEYS);
            end
        end
        win_dir = key_dir[win_slot];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        dir_d   = dir_q;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && win_found) begin
                    slot_d  = win_slot;
                    dir_d   = win_dir;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (move_ready) begin
                    xfer    = 1'b1;
                    ptr_d   = slot_q;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= SW'(NUM_KEYS - 1);
            slot_q  <= '0;
            dir_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            dir_q   <= dir_d;
        end
    end

    assign move_valid = (state_q == GRANT);
    assign busy       = (state_q != IDLE);
    assign move_dir   = dir_q;
    assign grant_slot = slot_q;

endmodule
